// File: rtl/clb_cfg_sequencer.sv
// clb_cfg_sequencer
// Configuration controller for a CLB array. It splits one upstream bitstream
// into fixed-size chunks, one per CLB in index order. It raises each CLB's cfg
// select while that CLB loads, then waits for every CLB to report configured.
// Once all are configured it broadcasts run. The stream path is a
// zero-latency pass-through gated by a registered "loading" flag.
// Control outputs are registered and decoded from the next state.
module clb_cfg_sequencer #(
   parameter int NUM_CLBS             = 4,
   parameter int BITSTREAM_DATA_WIDTH = 1,
   parameter int BEATS_PER_CLB        = 32,
   parameter int READY_TIMEOUT        = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            abort,
   input  logic                            s_bitstream_valid,
   input  logic [BITSTREAM_DATA_WIDTH-1:0] s_bitstream_data,
   output logic                            s_bitstream_ready,
   output logic [NUM_CLBS-1:0]             clb_cfg,
   output logic                            clb_bitstream_valid,
   output logic [BITSTREAM_DATA_WIDTH-1:0] clb_bitstream_data,
   input  logic [NUM_CLBS-1:0]             clb_bitstream_ready,
   input  logic [NUM_CLBS-1:0]             clb_cfg_ready,
   output logic                            run,
   output logic                            busy,
   output logic                            error
);

   // Counter widths, never narrower than one bit.
   localparam int CNT_W = (BEATS_PER_CLB > 1) ? $clog2(BEATS_PER_CLB) : 1;
   localparam int IDX_W = (NUM_CLBS > 1) ? $clog2(NUM_CLBS) : 1;
   localparam int TMR_W = (READY_TIMEOUT > 1) ? $clog2(READY_TIMEOUT) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS_PER_CLB - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLBS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(READY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LOAD       = 3'd1,
      ST_SWITCH     = 3'd2,
      ST_WAIT_READY = 3'd3,
      ST_RUN        = 3'd4,
      ST_ERROR      = 3'd5
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [TMR_W-1:0]    tmr_q,   tmr_d;

   // Registered control outputs, decoded from the next state.
   logic [NUM_CLBS-1:0] clb_cfg_q, clb_cfg_d;
   logic                load_q,    load_d;
   logic                run_q,     run_d;
   logic                busy_q,    busy_d;
   logic                error_q,   error_d;

   logic                xfer_s;
   logic                all_ready_s;

   // A beat moves only while loading and the currently selected CLB accepts it.
   assign xfer_s      = (state_q == ST_LOAD) && s_bitstream_valid && clb_bitstream_ready[idx_q];
   assign all_ready_s = &clb_cfg_ready;

   // Next-state logic: abort wins over everything, including a completing beat.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      if (abort) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         tmr_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_LOAD;
                  idx_d   = '0;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (xfer_s) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d = '0;
                     if (idx_q == IDX_LAST) begin
                        state_d = ST_WAIT_READY;
                        tmr_d   = '0;
                     end else begin
                        state_d = ST_SWITCH;
                     end
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            ST_SWITCH: begin
               // One idle cycle so the finished CLB sees its cfg fall first.
               state_d = ST_LOAD;
               idx_d   = idx_q + IDX_W'(1);
            end
            ST_WAIT_READY: begin
               // Ready is checked before the timeout so it wins a tie.
               if (all_ready_s) begin
                  state_d = ST_RUN;
               end else if (tmr_q == TMR_LAST) begin
                  state_d = ST_ERROR;
               end else begin
                  tmr_d = tmr_q + TMR_W'(1);
               end
            end
            ST_RUN, ST_ERROR: begin
               if (start) begin
                  state_d = ST_LOAD;
                  idx_d   = '0;
                  cnt_d   = '0;
                  tmr_d   = '0;
               end else begin
                  state_d = state_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
               tmr_d   = '0;
            end
         endcase
      end
   end

   // Decode the control outputs for the state being entered.
   always_comb begin
      clb_cfg_d = '0;
      load_d    = 1'b0;
      run_d     = 1'b0;
      busy_d    = 1'b0;
      error_d   = 1'b0;
      case (state_d)
         ST_LOAD: begin
            load_d = 1'b1;
            busy_d = 1'b1;
            for (int i = 0; i < NUM_CLBS; i++) begin
               clb_cfg_d[i] = (idx_d == IDX_W'(i));
            end
         end
         ST_SWITCH, ST_WAIT_READY: begin
            busy_d = 1'b1;
         end
         ST_RUN: begin
            run_d = 1'b1;
         end
         ST_ERROR: begin
            error_d = 1'b1;
         end
         ST_IDLE: begin
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs; reset is immediate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         tmr_q     <= '0;
         clb_cfg_q <= '0;
         load_q    <= 1'b0;
         run_q     <= 1'b0;
         busy_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         clb_cfg_q <= clb_cfg_d;
         load_q    <= load_d;
         run_q     <= run_d;
         busy_q    <= busy_d;
         error_q   <= error_d;
      end
   end

   // Stream pass-through: zero latency, gated to zero outside LOAD.
   always_comb begin
      s_bitstream_ready   = load_q & clb_bitstream_ready[idx_q];
      clb_bitstream_valid = load_q & s_bitstream_valid;
      if (load_q) begin
         clb_bitstream_data = s_bitstream_data;
      end else begin
         clb_bitstream_data = '0;
      end
   end

   assign clb_cfg = clb_cfg_q;
   assign run     = run_q;
   assign busy    = busy_q;
   assign error   = error_q;

endmodule

// File: tb/tb_clb_cfg_sequencer.sv
// Self-checking bench for clb_cfg_sequencer (2 CLBs, 4 beats each, timeout 4).
// The reference model tracks only how many beats have been accepted. From
// that count it derives which CLB should be selected, and it inserts the
// one-cycle gap that follows each completed CLB except the last. The wait
// phase is modelled as "all ready within TO cycles gives run, else error".
module tb_clb_cfg_sequencer;

   localparam int NC    = 2;
   localparam int BPC   = 4;
   localparam int TO    = 4;
   localparam int W     = 1;
   localparam int TOTAL = NC * BPC;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic          s_valid;
   logic [W-1:0]  s_data;
   logic          s_ready;
   logic [NC-1:0] cfg;
   logic          c_valid;
   logic [W-1:0]  c_data;
   logic [NC-1:0] c_rdy;
   logic [NC-1:0] c_cfg_rdy;
   logic          run;
   logic          busy;
   logic          error;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   clb_cfg_sequencer #(
      .NUM_CLBS            (NC),
      .BITSTREAM_DATA_WIDTH(W),
      .BEATS_PER_CLB       (BPC),
      .READY_TIMEOUT       (TO)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .start              (start),
      .abort              (abort),
      .s_bitstream_valid  (s_valid),
      .s_bitstream_data   (s_data),
      .s_bitstream_ready  (s_ready),
      .clb_cfg            (cfg),
      .clb_bitstream_valid(c_valid),
      .clb_bitstream_data (c_data),
      .clb_bitstream_ready(c_rdy),
      .clb_cfg_ready      (c_cfg_rdy),
      .run                (run),
      .busy               (busy),
      .error              (error)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start and expect CLB0 selected, run/error low, right after the edge.
   task automatic do_start();
      start = 1'b1; abort = 1'b0; s_valid = 1'b0; c_cfg_rdy = '0;
      tick();
      start = 1'b0;
      n_vec++;
      if ({cfg, busy, run, error} !== {NC'(1), 1'b1, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL start_load: got cfg/busy/run/err=%b expected %b",
                  {cfg, busy, run, error}, {NC'(1), 1'b1, 1'b0, 1'b0});
      end
   endtask

   // Feed one full bitstream. mode 0: no stalls, 1: random stalls and ignored
   // starts, 2: fixed backpressure pattern. abort_k >= 0 aborts on that beat.
   task automatic load_all(input logic [TOTAL-1:0] bits, input int mode, input int abort_k);
      int            k, sel, cyc;
      bit            gap, xfer;
      logic [NC-1:0] exp_cfg;
      logic [NC+4:0] exp_v, got_v;
      logic [BPC-1:0] seen [NC];
      k = 0; gap = 1'b0; cyc = 0;
      for (int i = 0; i < NC; i++) seen[i] = 'x;
      while (k < TOTAL && cyc < 200) begin
         sel = k / BPC;
         start = 1'b0; abort = 1'b0;
         case (mode)
            0: begin s_valid = 1'b1; c_rdy = '1; end
            1: begin
               s_valid = 1'($urandom_range(0, 3) != 0);
               c_rdy   = NC'($urandom);
               start   = 1'($urandom_range(0, 7) == 0);
            end
            default: begin
               s_valid  = (cyc % 3 != 2);
               c_rdy[1] = 1'(cyc % 2);
               c_rdy[0] = !(cyc >= 1 && cyc <= 3);
            end
         endcase
         s_data = W'(bits[k]);
         if (k == abort_k && !gap) begin abort = 1'b1; start = 1'b1; end
         exp_cfg = gap ? NC'(0) : (NC'(1) << sel);
         exp_v = {exp_cfg, gap ? 1'b0 : c_rdy[sel], gap ? 1'b0 : s_valid, 1'b1, 1'b0, 1'b0};
         #1;
         got_v = {cfg, s_ready, c_valid, busy, run, error};
         n_vec++;
         if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL load_outputs k=%0d cyc=%0d: got cfg/srdy/cval/busy/run/err=%b expected %b",
                     k, cyc, got_v, exp_v);
         end
         if (!gap && s_valid) begin
            n_vec++;
            if (c_data !== s_data) begin
               n_err++;
               $display("FAIL load_data k=%0d: got %b expected %b", k, c_data, s_data);
            end
         end
         xfer = !gap && s_valid && c_rdy[sel];
         if (xfer) seen[sel][k % BPC] = c_data[0];
         if (abort) begin
            tick();
            abort = 1'b0; start = 1'b0; s_valid = 1'b1; c_rdy = '1;
            #1;
            n_vec++;
            if ({cfg, s_ready, c_valid, busy, run, error} !== '0) begin
               n_err++;
               $display("FAIL abort_idle: got %b expected all zero",
                        {cfg, s_ready, c_valid, busy, run, error});
            end
            return;
         end
         if (xfer) k++;
         gap = xfer && (k % BPC == 0) && (k < TOTAL);
         cyc++;
         tick();
      end
      start = 1'b0;
      n_vec++;
      if (k != TOTAL) begin
         n_err++;
         $display("FAIL load_budget: got %0d beats expected %0d", k, TOTAL);
      end
      if (mode == 0) begin
         n_vec++;
         if (cyc != TOTAL + NC - 1) begin
            n_err++;
            $display("FAIL load_cycles: got %0d expected %0d", cyc, TOTAL + NC - 1);
         end
      end
      for (int i = 0; i < NC; i++) begin
         n_vec++;
         if (seen[i] !== bits[i*BPC +: BPC]) begin
            n_err++;
            $display("FAIL clb_beats clb=%0d: got %b expected %b", i, seen[i], bits[i*BPC +: BPC]);
         end
      end
   endtask

   // Wait phase: all-ready appears at WAIT cycle d (d >= TO means never).
   task automatic wait_ready(input int d, input logic [NC-1:0] partial);
      bit            exp_run;
      logic [NC+4:0] exp_v;
      for (int c = 0; c < TO; c++) begin
         start = 1'($urandom_range(0, 5) == 0); abort = 1'b0;
         s_valid = 1'($urandom); c_rdy = NC'($urandom);
         c_cfg_rdy = (c >= d) ? '1 : partial;
         #1;
         n_vec++;
         if ({cfg, s_ready, c_valid, busy, run, error} !== {NC'(0), 5'b00100}) begin
            n_err++;
            $display("FAIL wait_outputs c=%0d: got %b expected %b",
                     c, {cfg, s_ready, c_valid, busy, run, error}, {NC'(0), 5'b00100});
         end
         tick();
         if (c >= d) break;
      end
      start = 1'b0; c_cfg_rdy = partial; s_valid = 1'b1;
      exp_run = (d < TO);
      exp_v = {NC'(0), 1'b0, 1'b0, 1'b0, exp_run, !exp_run};
      for (int h = 0; h < 2; h++) begin
         #1;
         n_vec++;
         if ({cfg, s_ready, c_valid, busy, run, error} !== exp_v) begin
            n_err++;
            $display("FAIL wait_result d=%0d hold=%0d: got %b expected %b",
                     d, h, {cfg, s_ready, c_valid, busy, run, error}, exp_v);
         end
         tick();
      end
   endtask

   function automatic logic [NC-1:0] not_all_ready();
      logic [NC-1:0] p;
      p = NC'($urandom);
      if (&p) p[0] = 1'b0;
      return p;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b1; s_data = '1;
      c_rdy = '1; c_cfg_rdy = '1;
      #3;
      n_vec++;
      if ({cfg, s_ready, c_valid, c_data, busy, run, error} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got %b expected all zero",
                  {cfg, s_ready, c_valid, c_data, busy, run, error});
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      #1;
      n_vec++;
      if ({cfg, s_ready, c_valid, busy, run, error} !== '0) begin
         n_err++;
         $display("FAIL idle_after_reset: got %b expected all zero",
                  {cfg, s_ready, c_valid, busy, run, error});
      end
   endtask

   task automatic test_nominal();
      do_start();
      load_all(8'h4D, 0, -1);
      wait_ready(0, '0);
   endtask

   task automatic test_reconfig_from_run();
      do_start();
      load_all(TOTAL'($urandom), 1, -1);
      wait_ready(int'($urandom_range(0, TO - 1)), not_all_ready());
   endtask

   task automatic test_backpressure();
      do_start();
      load_all(TOTAL'($urandom), 2, -1);
      wait_ready(1, not_all_ready());
   endtask

   task automatic test_timeout();
      do_start();
      load_all(TOTAL'($urandom), 0, -1);
      wait_ready(TO, 2'b01);
      do_start();
      load_all(TOTAL'($urandom), 1, -1);
      wait_ready(TO - 1, 2'b10);
   endtask

   task automatic test_abort();
      do_start();
      load_all(TOTAL'($urandom), 0, BPC + 2);
      do_start();
      load_all(TOTAL'($urandom), 0, -1);
      wait_ready(0, '0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_vec++;
      if ({cfg, s_ready, c_valid, busy, run, error} !== '0) begin
         n_err++;
         $display("FAIL abort_from_run: got %b expected all zero",
                  {cfg, s_ready, c_valid, busy, run, error});
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         do_start();
         load_all(TOTAL'($urandom), 1, -1);
         wait_ready(int'($urandom_range(0, TO + 1)), not_all_ready());
      end
   endtask

   task automatic test_reset_mid_load();
      do_start();
      s_valid = 1'b1; c_rdy = '1;
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({cfg, s_ready, c_valid, c_data, busy, run, error} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got %b expected all zero",
                  {cfg, s_ready, c_valid, c_data, busy, run, error});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_vec++;
      if ({cfg, s_ready, c_valid, busy, run, error} !== '0) begin
         n_err++;
         $display("FAIL idle_after_async_reset: got %b expected all zero",
                  {cfg, s_ready, c_valid, busy, run, error});
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_reconfig_from_run();
      test_backpressure();
      test_timeout();
      test_abort();
      test_random();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
